// File: rtl/card_pkg.sv
// card_pkg: shared definitions for the card-identity pipeline.
//   NUM_RANKS        - number of per-rank XOR scorers (A..K)
//   SCORE_W          - mismatch score width, $clog2(28*40)
//   REJECT_THRESHOLD - largest best score still accepted when the
//                      RANK_CLASSIFIER_REJECT_EN build option is enabled
//   rank_t           - rank encoding, RANK_NONE marks "no rank / rejected"
//   state_t          - rank_classifier FSM state
//   sat_margin()     - runner-up minus best, clamped to the score range
package card_pkg;

  localparam int NUM_RANKS        = 13;
  localparam int SCORE_W          = 11;
  localparam int REJECT_THRESHOLD = 300;

  typedef enum logic [3:0] {
    RANK_A    = 4'd0,
    RANK_2    = 4'd1,
    RANK_3    = 4'd2,
    RANK_4    = 4'd3,
    RANK_5    = 4'd4,
    RANK_6    = 4'd5,
    RANK_7    = 4'd6,
    RANK_8    = 4'd7,
    RANK_9    = 4'd8,
    RANK_10   = 4'd9,
    RANK_J    = 4'd10,
    RANK_Q    = 4'd11,
    RANK_K    = 4'd12,
    RANK_NONE = 4'd15
  } rank_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SCAN    = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  // The runner-up register never drops below the best register, so the
  // plain difference already fits; the guard only keeps the result
  // well-defined should that invariant ever be broken. An uncaptured
  // runner-up (all-ones) naturally yields the largest possible margin.
  function automatic logic [SCORE_W-1:0] sat_margin(
    input logic [SCORE_W-1:0] second,
    input logic [SCORE_W-1:0] best
  );
    return (second >= best) ? (second - best) : '0;
  endfunction

endpackage

// File: rtl/rank_argmin_scan.sv
// rank_argmin_scan: running minimum / runner-up tracker, one lane per cycle.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - reinitialise: best = second = all-ones, best_idx = RANK_NONE
//   en         - fold (lane, score) into the running result this cycle
//   lane       - index of the lane presented on score
//   score      - score of that lane (all-ones for uncaptured lanes)
//   best       - smallest score seen since clear
//   second     - second-smallest score seen since clear
//   best_idx   - lane that produced best (RANK_NONE if nothing beat all-ones)
// Strict less-than everywhere: an equal score never displaces the earlier
// (lower-index) lane, but an equal score does become the runner-up, which
// is what drives the margin of a tie to zero.
module rank_argmin_scan
  import card_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               en,
  input  logic [3:0]         lane,
  input  logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best,
  output logic [SCORE_W-1:0] second,
  output logic [3:0]         best_idx
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best     <= '1;
      second   <= '1;
      best_idx <= 4'(RANK_NONE);
    end else if (clear) begin
      best     <= '1;
      second   <= '1;
      best_idx <= 4'(RANK_NONE);
    end else if (en) begin
      if (score < best) begin
        second   <= best;
        best     <= score;
        best_idx <= lane;
      end else if (score < second) begin
        second <= score;
      end
    end
  end

endmodule

// File: rtl/rank_classifier.sv
// rank_classifier: collects one mismatch score per rank, then picks the rank
// with the fewest mismatched pixels by a sequential argmin scan.
//
// Build option: RANK_CLASSIFIER_REJECT_EN - when defined, a best score above
// REJECT_THRESHOLD reports rank_idx = 15 (best_score/margin stay truthful).
//
// Parameters:
//   TIMEOUT - cycles after the first captured score before scanning an
//             incomplete set
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   frame_start  - pulse: discard everything and start a new collection
//   score_in     - packed scores, lane i at [i*SCORE_W +: SCORE_W]
//   score_valid  - per-lane one-cycle strobe, score_in lane is final
//   result_valid - result available (valid/ready source)
//   result_ready - consumer accepts the result
//   rank_idx     - winning rank 0..12, 15 = none / rejected
//   best_score   - minimum score
//   margin       - runner-up minus best
//   timed_out    - result was built from an incomplete score set
//   fsm_state    - current FSM state, for observation only
//
// Handshake: the result transfers on a rising edge where result_valid and
// result_ready are both high; result_valid, once raised, stays high with
// stable rank_idx/best_score/margin/timed_out until that transfer (or until
// frame_start / reset discards it). result_ready may be high before valid.
//
// Timing: final capture at edge N moves to SCAN; edges N+1..N+13 fold lanes
// 0..12; edge N+14 registers the outputs and raises result_valid.
module rank_classifier
  import card_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_start,
  input  logic [NUM_RANKS*SCORE_W-1:0] score_in,
  input  logic [NUM_RANKS-1:0]         score_valid,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [3:0]                   rank_idx,
  output logic [SCORE_W-1:0]           best_score,
  output logic [SCORE_W-1:0]           margin,
  output logic                         timed_out,
  output state_t                       fsm_state
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t               state;
  logic [SCORE_W-1:0]   bank [NUM_RANKS];
  logic [NUM_RANKS-1:0] mask;
  logic [NUM_RANKS-1:0] next_mask;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           scan_idx;

  logic                 scan_clear;
  logic                 scan_en;
  logic [SCORE_W-1:0]   lane_score;
  logic [SCORE_W-1:0]   run_best;
  logic [SCORE_W-1:0]   run_second;
  logic [3:0]           run_idx;

  assign fsm_state = state;
  assign next_mask = mask | score_valid;

  // The scanner is held in its initial state whenever we are not scanning,
  // so it is ready the cycle SCAN begins.
  assign scan_clear = (state != ST_SCAN);
  assign scan_en    = (state == ST_SCAN) && (scan_idx < 4'(NUM_RANKS));

  // Uncaptured lanes present all-ones so they can never win.
  always_comb begin
    lane_score = '1;
    if (scan_en && mask[scan_idx]) begin
      lane_score = bank[scan_idx];
    end
  end

  rank_argmin_scan u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (scan_clear),
    .en       (scan_en),
    .lane     (scan_idx),
    .score    (lane_score),
    .best     (run_best),
    .second   (run_second),
    .best_idx (run_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_COLLECT;
      mask         <= '0;
      cnt          <= '0;
      scan_idx     <= '0;
      result_valid <= 1'b0;
      rank_idx     <= 4'(RANK_NONE);
      best_score   <= '1;
      margin       <= '0;
      timed_out    <= 1'b0;
      for (int i = 0; i < NUM_RANKS; i++) begin
        bank[i] <= '1;
      end
    end else if (frame_start) begin
      // Highest priority: abandons any scan or pending result and
      // swallows a same-cycle score_valid.
      state        <= ST_COLLECT;
      mask         <= '0;
      cnt          <= '0;
      scan_idx     <= '0;
      result_valid <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          for (int i = 0; i < NUM_RANKS; i++) begin
            if (score_valid[i]) begin
              bank[i] <= score_in[i*SCORE_W +: SCORE_W];
            end
          end
          mask <= next_mask;
          // The counter only runs once something has been captured.
          if (mask != '0) begin
            cnt <= cnt + 1'b1;
          end
          if (next_mask == '1) begin
            state    <= ST_SCAN;
            scan_idx <= '0;
          end else if ((mask != '0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
            state     <= ST_SCAN;
            scan_idx  <= '0;
            timed_out <= 1'b1;
          end
        end

        ST_SCAN: begin
          if (scan_idx == 4'(NUM_RANKS)) begin
            best_score   <= run_best;
            margin       <= sat_margin(run_second, run_best);
`ifdef RANK_CLASSIFIER_REJECT_EN
            rank_idx     <= (run_best > SCORE_W'(REJECT_THRESHOLD)) ?
                            4'(RANK_NONE) : run_idx;
`else
            rank_idx     <= run_idx;
`endif
            result_valid <= 1'b1;
            state        <= ST_HOLD;
          end else begin
            scan_idx <= scan_idx + 4'd1;
          end
        end

        ST_HOLD: begin
          // result_valid is always high here, so ready alone completes
          // the transfer.
          if (result_ready) begin
            result_valid <= 1'b0;
            mask         <= '0;
            cnt          <= '0;
            timed_out    <= 1'b0;
            state        <= ST_COLLECT;
          end
        end

        default: begin
          state <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rank_classifier.sv
// tb_rank_classifier: directed self-checking bench for rank_classifier
// (built with TIMEOUT = 64 to keep the incomplete-set case short).
module tb_rank_classifier;
  import card_pkg::*;

  localparam int TMO = 64;
  localparam int W   = 4 + SCORE_W + SCORE_W + 1;

  logic                         clk;
  logic                         rst_n;
  logic                         frame_start;
  logic [NUM_RANKS*SCORE_W-1:0] score_in;
  logic [NUM_RANKS-1:0]         score_valid;
  logic                         result_valid;
  logic                         result_ready;
  logic [3:0]                   rank_idx;
  logic [SCORE_W-1:0]           best_score;
  logic [SCORE_W-1:0]           margin;
  logic                         timed_out;
  state_t                       fsm_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur;

  rank_classifier #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .score_in     (score_in),
    .score_valid  (score_valid),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .rank_idx     (rank_idx),
    .best_score   (best_score),
    .margin       (margin),
    .timed_out    (timed_out),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // comparison point
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic fill(input int base);
    for (int i = 0; i < NUM_RANKS; i++) score_in[i*SCORE_W +: SCORE_W] = SCORE_W'(base);
  endtask

  task automatic set_lane(input int lane, input int val);
    score_in[lane*SCORE_W +: SCORE_W] = SCORE_W'(val);
  endtask

  // Drives score_valid for exactly one rising edge; returns at the
  // falling edge right after that capture edge.
  task automatic pulse_lanes(input logic [NUM_RANKS-1:0] lanes);
    @(negedge clk);
    score_valid = lanes;
    @(negedge clk);
    score_valid = '0;
  endtask

  task automatic expect_result(input int rank, input int best, input int mar, input int tmo);
    exp_q.push_back({4'(rank), SCORE_W'(best), SCORE_W'(mar), 1'(tmo)});
  endtask

  // Counts falling edges until result_valid, bounded.
  task automatic wait_result(input string tag, output int lat);
    lat = 0;
    while (!result_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_seen"}, int'(result_valid), 1);
  endtask

  // scoreboard: pop and compare the presented result
  task automatic check_result(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 0, 1);
    end else begin
      cur = exp_q.pop_front();
      chk({tag, "_rank"},   int'(rank_idx),   int'(cur[W-1 -: 4]));
      chk({tag, "_best"},   int'(best_score), int'(cur[W-5 -: SCORE_W]));
      chk({tag, "_margin"}, int'(margin),     int'(cur[SCORE_W -: SCORE_W]));
      chk({tag, "_tmo"},    int'(timed_out),  int'(cur[0]));
    end
  endtask

  task automatic accept(input string tag);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({tag, "_acc_valid"}, int'(result_valid), 0);
    chk({tag, "_acc_state"}, int'(fsm_state), int'(ST_COLLECT));
  endtask

  initial begin
    int lat;
    int unstable;
    rst_n        = 1'b0;
    frame_start  = 1'b0;
    score_in     = '0;
    score_valid  = '0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_rank",  int'(rank_idx), 15);
    chk("rst_best",  int'(best_score), 2047);
    chk("rst_margin", int'(margin), 0);
    chk("rst_tmo",   int'(timed_out), 0);
    chk("rst_state", int'(fsm_state), int'(ST_COLLECT));

    // all lanes in one cycle, lane 12 lowest
    fill(500); set_lane(12, 40);
    expect_result(12, 40, 460, 0);
    pulse_lanes('1);
    wait_result("t1", lat);
    chk("t1_latency", lat, 14);
    check_result("t1");
    accept("t1");

    // tie between lanes 3 and 7; ready high before valid
    fill(900); set_lane(3, 100); set_lane(7, 100);
    expect_result(3, 100, 0, 0);
    result_ready = 1'b1;
    pulse_lanes('1);
    wait_result("t2", lat);
    chk("t2_latency", lat, 14);
    check_result("t2");
    @(negedge clk);
    chk("t2_early_ready", int'(result_valid), 0);
    result_ready = 1'b0;

    // repeat capture on lane 4 overwrites, then hold with ready low
    fill(900); set_lane(4, 20);
    pulse_lanes(13'h0010);
    set_lane(4, 800);
    pulse_lanes(13'h0010);
    set_lane(9, 30);
    expect_result(9, 30, 770, 0);
    pulse_lanes(~13'h0010);
    wait_result("t3", lat);
    chk("t3_latency", lat, 14);
    check_result("t3");
    unstable = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        fill(1); score_valid = '1;
      end else begin
        score_valid = '0;
      end
      @(negedge clk);
      if (result_valid !== 1'b1 || rank_idx !== 4'd9 || best_score !== 11'd30 ||
          margin !== 11'd770 || timed_out !== 1'b0) unstable++;
    end
    score_valid = '0;
    chk("t3_hold_stable", unstable, 0);
    accept("t3");

    // incomplete set, lanes 0..5 only
    fill(600); set_lane(2, 50);
    expect_result(2, 50, 550, 1);
    pulse_lanes(13'h003F);
    wait_result("t4", lat);
    chk("t4_after_timeout", int'(lat >= TMO), 1);
    check_result("t4");
    accept("t4");
    chk("t4_tmo_cleared", int'(timed_out), 0);

    // frame_start mid-scan discards the first set
    fill(500); set_lane(0, 10);
    pulse_lanes('1);
    repeat (4) @(negedge clk);
    chk("t5_in_scan", int'(fsm_state), int'(ST_SCAN));
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("t5_fs_state", int'(fsm_state), int'(ST_COLLECT));
    chk("t5_fs_valid", int'(result_valid), 0);
    fill(700); set_lane(5, 10);
    expect_result(5, 10, 690, 0);
    pulse_lanes('1);
    wait_result("t5", lat);
    chk("t5_latency", lat, 14);
    check_result("t5");
    accept("t5");

    // best score just above the reject threshold
    fill(1000); set_lane(8, 301);
`ifdef RANK_CLASSIFIER_REJECT_EN
    expect_result(15, 301, 699, 0);
`else
    expect_result(8, 301, 699, 0);
`endif
    pulse_lanes('1);
    wait_result("t6", lat);
    check_result("t6");

    // asynchronous reset while holding a result
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", int'(result_valid), 0);
    chk("t7_rst_rank",  int'(rank_idx), 15);
    chk("t7_rst_state", int'(fsm_state), int'(ST_COLLECT));
    #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t7_after_valid", int'(result_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
